// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract sequencer sharing one full-adder cell
// One operand bit pair per clock, LSB first; carry held in a flop between cycles.

module fulladder (
  output logic sum,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] sum_shift;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_sum, cell_co;
  logic             accept, last_bit;

  fulladder u_fa (
    .sum (cell_sum),
    .co  (cell_co),
    .a   (op_a[0]),
    .b   (op_b[0]),
    .ci  (carry)
  );

  assign accept   = start && (state == IDLE || state == DONE);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign sum_shift = cell_sum;
    end else begin : g_wn
      assign sum_shift = {cell_sum, sum[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_a  <= a;
        op_b  <= sub ? ~b : b;
        carry <= sub ? 1'b1 : ci;
        cnt   <= '0;
        sum   <= '0;
      end else if (state == RUN) begin
        sum   <= sum_shift;
        op_a  <= op_a >> 1;
        op_b  <= op_b >> 1;
        carry <= cell_co;
        cnt   <= cnt + CW'(1);
        if (last_bit) begin
          co  <= cell_co;
          ovf <= cell_co ^ carry;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end
endmodule
